// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults and constants for the MIPS register file
package reg_file_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;
  localparam int ZERO_REG     = 0;

endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - decode/writeback side bus of the register file
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] REG_address1;
  logic [ADDR_W-1:0] REG_address2;
  logic [ADDR_W-1:0] REG_address_wb;
  logic              regwrite;
  logic [DATA_W-1:0] data_wb;
  logic [DATA_W-1:0] data_out_1;
  logic [DATA_W-1:0] data_out_2;

  modport master (
    output REG_address1, REG_address2, REG_address_wb, regwrite, data_wb,
    input  data_out_1, data_out_2
  );

  modport slave (
    input  REG_address1, REG_address2, REG_address_wb, regwrite, data_wb,
    output data_out_1, data_out_2
  );

endinterface

// File: rtl/reg_file_read_port.sv
// rtl/reg_file_read_port.sv - combinational read port; address 0 reads zero
// Optional same-cycle write forwarding under REG_FILE_WRITE_BYPASS_EN.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [1:NUM_REGS-1],
`ifdef REG_FILE_WRITE_BYPASS_EN
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
`endif
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) data = regs[i];
    end
`ifdef REG_FILE_WRITE_BYPASS_EN
    // Write-before-read: the value landing this cycle wins over storage.
    if (wb_en && (wb_addr != ADDR_W'(ZERO_REG)) && (wb_addr == addr)) data = wb_data;
`endif
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two async reads, one sync write, r0 = 0
// Optional macro: REG_FILE_WRITE_BYPASS_EN forwards write data to matching reads.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  reg_file_if.slave  bus
);

  // Entry 0 has no storage; the read ports synthesise its zero.
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (bus.regwrite) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (bus.REG_address_wb == ADDR_W'(i)) regs[i] <= bus.data_wb;
      end
    end
  end

`ifdef REG_FILE_WRITE_BYPASS_EN
  logic wb_en;
  assign wb_en = bus.regwrite && !reset;
`endif

  reg_file_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_read_port_1 (
    .addr    (bus.REG_address1),
    .regs    (regs),
`ifdef REG_FILE_WRITE_BYPASS_EN
    .wb_en   (wb_en),
    .wb_addr (bus.REG_address_wb),
    .wb_data (bus.data_wb),
`endif
    .data    (bus.data_out_1)
  );

  reg_file_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_read_port_2 (
    .addr    (bus.REG_address2),
    .regs    (regs),
`ifdef REG_FILE_WRITE_BYPASS_EN
    .wb_en   (wb_en),
    .wb_addr (bus.REG_address_wb),
    .wb_data (bus.data_wb),
`endif
    .data    (bus.data_out_2)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;

  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;
  logic [31:0] fill_vals [1:15];

  reg_file_if bus ();

  reg_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    bus.REG_address_wb = addr;
    bus.data_wb        = data;
    bus.regwrite       = 1'b1;
    tick();
    bus.regwrite       = 1'b0;
  endtask

  task automatic rd2(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] e1, input logic [31:0] e2);
    bus.REG_address1 = a1;
    bus.REG_address2 = a2;
    #1;
    check($sformatf("%s_p1_a%0d", tag, a1), bus.data_out_1, e1);
    check($sformatf("%s_p2_a%0d", tag, a2), bus.data_out_2, e2);
  endtask

  initial begin
    fill_vals[1]  = 32'hDEADBEEF; fill_vals[2]  = 32'hCAFEBABE;
    fill_vals[3]  = 32'h12345678; fill_vals[4]  = 32'h87654321;
    fill_vals[5]  = 32'hA5A5A5A5; fill_vals[6]  = 32'h5A5A5A5A;
    fill_vals[7]  = 32'h01234567; fill_vals[8]  = 32'h89ABCDEF;
    fill_vals[9]  = 32'hFEDCBA98; fill_vals[10] = 32'h76543210;
    fill_vals[11] = 32'hAAAAAAAA; fill_vals[12] = 32'h55555555;
    fill_vals[13] = 32'h13579BDF; fill_vals[14] = 32'h2468ACE0;
    fill_vals[15] = 32'h9ABC9ABC;

    reset              = 1'b1;
    bus.regwrite       = 1'b0;
    bus.REG_address1   = '0;
    bus.REG_address2   = '0;
    bus.REG_address_wb = '0;
    bus.data_wb        = '0;
    tick();
    reset = 1'b0;

    for (int a = 0; a < 32; a++) rd2("rst0", 5'(a), 5'(31 - a), 32'h0, 32'h0);

    for (int a = 1; a <= 15; a++) wr(5'(a), fill_vals[a]);
    for (int a = 1; a < 15; a += 2) rd2("fill", 5'(a), 5'(a + 1), fill_vals[a], fill_vals[a + 1]);
    rd2("fill", 5'd15, 5'd0, fill_vals[15], 32'h0);
    rd2("unwritten", 5'd16, 5'd31, 32'h0, 32'h0);

    wr(5'd0, 32'hFFFFFFFF);
    rd2("zero_reg", 5'd0, 5'd0, 32'h0, 32'h0);

    bus.REG_address_wb = 5'd1;
    bus.data_wb        = 32'h11111111;
    bus.regwrite       = 1'b0;
    tick();
    rd2("wr_dis", 5'd1, 5'd2, 32'hDEADBEEF, 32'hCAFEBABE);

    rd2("dual", 5'd12, 5'd12, 32'h55555555, 32'h55555555);

    bus.REG_address1   = 5'd5;
    bus.REG_address2   = 5'd6;
    bus.REG_address_wb = 5'd5;
    bus.data_wb        = 32'h0F0F0F0F;
    bus.regwrite       = 1'b1;
    #1;
`ifdef REG_FILE_WRITE_BYPASS_EN
    check("same_cyc_pre", bus.data_out_1, 32'h0F0F0F0F);
`else
    check("same_cyc_pre", bus.data_out_1, 32'hA5A5A5A5);
`endif
    check("same_cyc_other", bus.data_out_2, 32'h5A5A5A5A);
    tick();
    bus.regwrite = 1'b0;
    check("same_cyc_post", bus.data_out_1, 32'h0F0F0F0F);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 1; a <= 6; a++) rd2("mid_rst", 5'(a), 5'(a), 32'h0, 32'h0);
    rd2("mid_rst", 5'd12, 5'd15, 32'h0, 32'h0);

    wr(5'd3, 32'h77777777);
    rd2("rewrite", 5'd3, 5'd4, 32'h77777777, 32'h0);

    reset              = 1'b1;
    bus.REG_address_wb = 5'd3;
    bus.data_wb        = 32'h5A5A5A5A;
    bus.regwrite       = 1'b1;
    tick();
    reset        = 1'b0;
    bus.regwrite = 1'b0;
    rd2("rst_vs_wr", 5'd3, 5'd3, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
